// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, default widths, opcode field
// position and the opcode constants that the control unit also decodes.
package cpu_pkg;

    localparam int unsigned DEF_PC_W    = 10;
    localparam int unsigned DEF_INSTR_W = 16;
    localparam int unsigned DEF_OP_W    = 6;

    // Opcode occupies the top OP_W bits of the instruction word.
    localparam int unsigned OP_MSB = DEF_INSTR_W - 1;
    localparam int unsigned OP_LSB = DEF_INSTR_W - DEF_OP_W;

    localparam logic [DEF_OP_W-1:0] OP_JUMP = 6'h01;
    localparam logic [DEF_OP_W-1:0] OP_LI   = 6'h08;

    typedef enum logic [1:0] {
        StRst  = 2'd0,
        StReq  = 2'd1,
        StExec = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus: request/address out of fetch, data/ack back.
interface fetch_unit_if #(
    parameter int unsigned PC_W    = cpu_pkg::DEF_PC_W,
    parameter int unsigned INSTR_W = cpu_pkg::DEF_INSTR_W
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/ras_stack.sv
// Return-address stack. Circular storage: a push while full overwrites the
// oldest entry; a pop while empty leaves the stack untouched.
module ras_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [WIDTH-1:0] entries_q [DEPTH];
    logic [PtrW-1:0]  wr_q;
    logic [CntW-1:0]  cnt_q;
    logic [PtrW-1:0]  top_idx;
    logic [PtrW-1:0]  wr_next;
    logic             do_push;
    logic             do_pop;

    // Pointer arithmetic wraps explicitly so non-power-of-two depths work.
    always_comb begin
        top_idx = (wr_q == '0) ? LastIdx : wr_q - PtrW'(1);
        wr_next = (wr_q == LastIdx) ? '0 : wr_q + PtrW'(1);
        full    = (cnt_q == FullCnt);
        empty   = (cnt_q == '0);
        top     = entries_q[top_idx];
        do_push = push && !pop;
        do_pop  = pop && !push && !empty;
    end

    // Write pointer and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (do_push) begin
            wr_q <= wr_next;
            if (!full) cnt_q <= cnt_q + CntW'(1);
        end else if (do_pop) begin
            wr_q  <= top_idx;
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    // Entry storage needs no reset; occupancy gates what is readable.
    always_ff @(posedge clk) begin
        if (do_push) entries_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, instruction register.
// Define FETCH_STACK_EN to add call/return via a return-address stack.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned INSTR_W     = DEF_INSTR_W,
    parameter int unsigned OP_W        = DEF_OP_W,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_inc,
    input  logic               s_push,
    input  logic               s_pop,
    fetch_unit_if.master       bus,
    output logic [INSTR_W-1:0] instr,
    output logic [OP_W-1:0]    Opcode,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               stack_ovf,
    output logic               stack_unf
);
    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0]    pc_seq;
    logic [PC_W-1:0]    pc_seq_or_jump;

    assign pc_seq         = pc_q + PC_W'(1);
    assign pc_seq_or_jump = s_inc ? pc_seq : ir_q[PC_W-1:0];

`ifdef FETCH_STACK_EN
    logic            push_en, pop_en;
    logic            stk_full, stk_empty;
    logic [PC_W-1:0] stk_top;
    logic            ovf_q, unf_q;

    ras_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_ras_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push_en),
        .pop       (pop_en),
        .push_data (pc_seq),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Sticky stack error flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (push_en & stk_full);
            unf_q <= unf_q | (pop_en & stk_empty);
        end
    end

    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
`else
    logic unused_stack;
    assign unused_stack = ^{s_push, s_pop, STACK_DEPTH[0]};
    assign stack_ovf    = 1'b0;
    assign stack_unf    = 1'b0;
`endif

    // Next-state, PC update and handshake outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        bus.imem_req = 1'b0;
        instr_valid = 1'b0;
`ifdef FETCH_STACK_EN
        push_en     = 1'b0;
        pop_en      = 1'b0;
`endif
        unique case (state_q)
            StRst: state_d = StReq;
            StReq: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                instr_valid = 1'b1;
                state_d     = StReq;
`ifdef FETCH_STACK_EN
                // Push and pop together cancel out; the PC then follows s_inc.
                if (s_push && !s_pop) begin
                    push_en = 1'b1;
                    pc_d    = ir_q[PC_W-1:0];
                end else if (s_pop && !s_push) begin
                    pop_en = 1'b1;
                    pc_d   = stk_empty ? '0 : stk_top;
                end else begin
                    pc_d = pc_seq_or_jump;
                end
`else
                pc_d = pc_seq_or_jump;
`endif
            end
            default: state_d = StRst;
        endcase
    end

    // State, PC and IR registers; reset drops any outstanding request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StRst;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign pc            = pc_q;
    assign instr         = ir_q;
    assign Opcode        = ir_q[INSTR_W-1 -: OP_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; honours FETCH_STACK_EN.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_inc, s_push, s_pop;
    logic [15:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [9:0]  pc;
    logic        stack_ovf, stack_unf;

    int passed = 0;
    int total  = 0;

    // Memory model: ack after ws wait cycles, or forced regardless of req.
    logic [15:0] mem [0:1023];
    int          ws = 0;
    int          wait_cnt = 0;
    logic        mem_en = 1'b0;
    logic        force_ack = 1'b0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .s_inc       (s_inc),
        .s_push      (s_push),
        .s_pop       (s_pop),
        .bus         (bus),
        .instr       (instr),
        .Opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    always #5 clk = ~clk;

    assign bus.imem_ack   = force_ack | (mem_en & bus.imem_req & (wait_cnt >= ws));
    assign bus.imem_rdata = force_ack ? 16'hBEEF : mem[bus.imem_addr];

    always @(posedge clk) begin
        if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // Step negedges until instr_valid, bounded; n is the number of steps.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (instr_valid !== 1'b1 && n < 40);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if ({pc, instr, instr_valid, bus.imem_req} !== 28'h0) $display("FAIL reset_outs: pc=%h ir=%h v=%b req=%b expected all 0", pc, instr, instr_valid, bus.imem_req); else passed++;
        total++; if ({stack_ovf, stack_unf} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {stack_ovf, stack_unf}); else passed++;
        reset = 1'b1;
        total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_state_req: got %b expected 0", bus.imem_req); else passed++;
        @(negedge clk);
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h000) $display("FAIL first_req: req=%b addr=%h expected 1/000", bus.imem_req, bus.imem_addr); else passed++;
        total++; if (instr_valid !== 1'b0 || instr !== 16'h0) $display("FAIL first_req_ir: v=%b ir=%h expected 0/0000", instr_valid, instr); else passed++;
    endtask

    task automatic test_sequential();
        logic [15:0] words [3];
        logic [5:0]  ops [3];
        int n;
        words = '{16'h80F1, 16'h8012, 16'h2123};
        ops   = '{6'h20, 6'h20, 6'h08};
        mem_en = 1'b1;
        s_inc  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(n);
            total++; if (n !== ((k == 0) ? 1 : 2)) $display("FAIL seq_spacing[%0d]: got %0d cycles expected %0d", k, n, (k == 0) ? 1 : 2); else passed++;
            total++; if (opcode !== ops[k]) $display("FAIL seq_opcode[%0d]: got %h expected %h", k, opcode, ops[k]); else passed++;
            total++; if (instr !== words[k]) $display("FAIL seq_instr[%0d]: got %h expected %h", k, instr, words[k]); else passed++;
            total++; if (pc !== 10'(k)) $display("FAIL seq_pc[%0d]: got %h expected %h", k, pc, 10'(k)); else passed++;
        end
        @(negedge clk);
        total++; if (pc !== 10'h003 || bus.imem_addr !== 10'h003 || bus.imem_req !== 1'b1) $display("FAIL seq_pc3: pc=%h addr=%h req=%b expected 003/003/1", pc, bus.imem_addr, bus.imem_req); else passed++;
    endtask

    task automatic test_jump_wait();
        int n;
        s_inc = 1'b0;
        wait_valid(n);
        total++; if (instr !== 16'h040F || opcode !== 6'h01) $display("FAIL jump_instr: ir=%h op=%h expected 040F/01", instr, opcode); else passed++;
        ws = 3;
        @(negedge clk);
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h00F) $display("FAIL jump_addr: req=%b addr=%h expected 1/00F", bus.imem_req, bus.imem_addr); else passed++;
        wait_valid(n);
        total++; if (n !== 4) $display("FAIL wait_latency: got %0d cycles expected 4", n); else passed++;
        total++; if (instr !== 16'h07FF) $display("FAIL wait_instr: got %h expected 07FF", instr); else passed++;
    endtask

    task automatic test_wrap();
        int n;
        ws = 0;
        @(negedge clk);
        total++; if (bus.imem_addr !== 10'h3FF) $display("FAIL wrap_setup: addr=%h expected 3FF", bus.imem_addr); else passed++;
        s_inc = 1'b1;
        wait_valid(n);
        total++; if (pc !== 10'h3FF || n !== 1) $display("FAIL wrap_exec: pc=%h n=%0d expected 3FF/1", pc, n); else passed++;
        @(negedge clk);
        total++; if (bus.imem_addr !== 10'h000 || pc !== 10'h000) $display("FAIL wrap_addr: addr=%h pc=%h expected 000/000", bus.imem_addr, pc); else passed++;
        total++; if ({stack_ovf, stack_unf} !== 2'b00) $display("FAIL wrap_flags: got %b expected 00", {stack_ovf, stack_unf}); else passed++;
    endtask

    task automatic test_reset_ack();
        int n;
        mem_en = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        total++; if (bus.imem_req !== 1'b0 || instr !== 16'h0 || pc !== 10'h0) $display("FAIL rstreq_drop: req=%b ir=%h pc=%h expected 0/0000/000", bus.imem_req, instr, pc); else passed++;
        reset     = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        total++; if (instr !== 16'h0 || instr_valid !== 1'b0) $display("FAIL late_ack: ir=%h v=%b expected 0000/0", instr, instr_valid); else passed++;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h0 || pc !== 10'h0) $display("FAIL restart: req=%b addr=%h pc=%h expected 1/000/000", bus.imem_req, bus.imem_addr, pc); else passed++;
        force_ack = 1'b0;
        mem_en    = 1'b1;
        wait_valid(n);
        total++; if (n !== 1 || instr !== 16'h80F1) $display("FAIL refetch: n=%0d ir=%h expected 1/80F1", n, instr); else passed++;
    endtask

`ifdef FETCH_STACK_EN
    task automatic test_stack();
        logic [9:0] push_pc [5];
        logic [9:0] pop_exp [5];
        int n;
        push_pc = '{10'h000, 10'h010, 10'h020, 10'h030, 10'h040};
        pop_exp = '{10'h041, 10'h031, 10'h021, 10'h011, 10'h000};
        mem[10'h000] = 16'h0010;
        mem[10'h010] = 16'h0020;
        mem[10'h020] = 16'h0030;
        mem[10'h030] = 16'h0040;
        mem[10'h040] = 16'h0050;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            wait_valid(n);
            total++; if (pc !== push_pc[k]) $display("FAIL push_pc[%0d]: got %h expected %h", k, pc, push_pc[k]); else passed++;
            s_push = 1'b1;
            @(negedge clk);
            s_push = 1'b0;
            total++; if (pc !== push_pc[k] + 10'h010) $display("FAIL push_jump[%0d]: got %h expected %h", k, pc, push_pc[k] + 10'h010); else passed++;
            total++; if (stack_ovf !== (k == 4)) $display("FAIL push_ovf[%0d]: got %b expected %b", k, stack_ovf, (k == 4)); else passed++;
        end
        for (int k = 0; k < 5; k++) begin
            wait_valid(n);
            s_pop = 1'b1;
            @(negedge clk);
            s_pop = 1'b0;
            total++; if (pc !== pop_exp[k]) $display("FAIL pop_pc[%0d]: got %h expected %h", k, pc, pop_exp[k]); else passed++;
            total++; if (stack_unf !== (k == 4)) $display("FAIL pop_unf[%0d]: got %b expected %b", k, stack_unf, (k == 4)); else passed++;
        end
        wait_valid(n);
        s_push = 1'b1;
        @(negedge clk);
        wait_valid(n);
        s_pop = 1'b1;
        s_inc = 1'b1;
        @(negedge clk);
        s_push = 1'b0;
        s_pop  = 1'b0;
        total++; if (pc !== 10'h011) $display("FAIL pushpop_pc: got %h expected 011", pc); else passed++;
        wait_valid(n);
        s_pop = 1'b1;
        @(negedge clk);
        s_pop = 1'b0;
        total++; if (pc !== 10'h001) $display("FAIL pushpop_stack: pop got %h expected 001", pc); else passed++;
        total++; if (stack_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", stack_ovf); else passed++;
    endtask
`else
    task automatic test_stack_ignored();
        int n;
        s_inc  = 1'b1;
        s_push = 1'b1;
        @(negedge clk);
        s_push = 1'b0;
        total++; if (pc !== 10'h001) $display("FAIL push_ignored: pc=%h expected 001", pc); else passed++;
        wait_valid(n);
        s_pop = 1'b1;
        @(negedge clk);
        s_pop = 1'b0;
        total++; if (pc !== 10'h002) $display("FAIL pop_ignored: pc=%h expected 002", pc); else passed++;
        total++; if ({stack_ovf, stack_unf} !== 2'b00) $display("FAIL flags_const: got %b expected 00", {stack_ovf, stack_unf}); else passed++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[0]      = 16'h80F1;
        mem[1]      = 16'h8012;
        mem[2]      = 16'h2123;
        mem[3]      = 16'h040F;
        mem[10'h00F] = 16'h07FF;
        mem[10'h3FF] = 16'h2123;
        s_inc  = 1'b1;
        s_push = 1'b0;
        s_pop  = 1'b0;
        test_reset();
        test_sequential();
        test_jump_wait();
        test_wrap();
        test_reset_ack();
`ifdef FETCH_STACK_EN
        test_stack();
`else
        test_stack_ignored();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
